// File: rtl/dp_ram_pkg.sv
// Shared defaults for the generic dual-port buffer geometry.
package dp_ram_pkg;
  localparam int DP_RAM_DATA_WIDTH = 8;
  localparam int DP_RAM_ADDR_WIDTH = 8;
endpackage

// File: rtl/dp_ram_out_reg.sv
// Read-data output register, async reset to zero; 1 cycle, no backpressure.
module dp_ram_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] dat_d,
  output logic [WIDTH-1:0] dat_q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dat_q <= '0;
    end else begin
      dat_q <= dat_d;
    end
  end

endmodule

// File: rtl/dp_ram.sv
// Simple dual-port RAM: A write-only, B read-only, one clock, read-first.
// Read latency 1 cycle, always ready (no backpressure); array is not reset.
module dp_ram
  import dp_ram_pkg::*;
#(
  parameter int DATA_WIDTH = DP_RAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = DP_RAM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  input  logic [ADDR_WIDTH-1:0] addrb,
  output logic [DATA_WIDTH-1:0] doutb
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] doutb_d;
  logic [DATA_WIDTH-1:0] doutb_q;

  // No reset on the array so it maps onto block RAM; rst only gates writes.
  always_ff @(posedge clk) begin
    if (!rst && wea) begin
      mem[addra] <= dina;
    end
  end

  // Combinational read feeding the output register gives read-first collisions.
  always_comb begin
    doutb_d = mem[addrb];
  end

  dp_ram_out_reg #(
    .WIDTH (DATA_WIDTH)
  ) u_out_reg (
    .clk   (clk),
    .rst   (rst),
    .dat_d (doutb_d),
    .dat_q (doutb_q)
  );

  assign doutb = doutb_q;

endmodule

// File: tb/tb_dp_ram.sv
// Directed checks of dp_ram: reset, fill/readback, concurrent access, collision, boundaries.
module tb_dp_ram;

  logic       clk;
  logic       rst;
  logic       wea;
  logic [7:0] addra;
  logic [7:0] dina;
  logic [7:0] addrb;
  logic [7:0] doutb;

  int total_cnt;
  int bad_cnt;

  dp_ram #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (8)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .wea   (wea),
    .addra (addra),
    .dina  (dina),
    .addrb (addrb),
    .doutb (doutb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=0x%02h exp=0x%02h", tag, got, exp);
    end
  endtask

  // Advance one clock edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    rst   = 1'b1;
    wea   = 1'b0;
    addra = '0;
    dina  = '0;
    addrb = '0;
    tick();
    tick();
    chk("reset_state", doutb, 8'h00);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      wea = 1'b1; addra = 8'(i); dina = 8'(8'h10 + i);
      tick();
    end
    wea = 1'b0;

    for (int i = 0; i < 10; i++) begin
      addrb = 8'(i);
      tick();
      chk($sformatf("fill_rd%0d", i), doutb, 8'(8'h10 + i));
    end

    for (int j = 0; j < 5; j++) begin
      wea = 1'b1; addra = 8'(j); dina = 8'(j); addrb = 8'(j + 1);
      tick();
      chk($sformatf("conc_rd%0d", j + 1), doutb, 8'(8'h11 + j));
    end
    wea = 1'b0;
    for (int j = 0; j < 5; j++) begin
      addrb = 8'(j);
      tick();
      chk($sformatf("conc_wr%0d", j), doutb, 8'(j));
    end

    wea = 1'b1; addra = 8'd7; dina = 8'hAA;
    tick();
    addrb = 8'd7; dina = 8'hBB;
    tick();
    chk("collide_old", doutb, 8'hAA);
    wea = 1'b0;
    tick();
    chk("collide_new", doutb, 8'hBB);

    wea = 1'b1; addra = 8'd255; dina = 8'hFF;
    tick();
    addra = 8'd0; dina = 8'h01;
    tick();
    wea = 1'b0; addrb = 8'd255;
    tick();
    chk("bound_255", doutb, 8'hFF);
    addrb = 8'd0;
    tick();
    chk("bound_0", doutb, 8'h01);

    wea = 1'b0; addra = 8'd5; dina = 8'hCC; addrb = 8'd9;
    tick();
    addrb = 8'd5;
    tick();
    chk("wea_low", doutb, 8'h15);

    wea = 1'b1; addra = 8'd20; dina = 8'h5A;
    tick();
    wea = 1'b0; addrb = 8'd20;
    tick();
    chk("pre_reset", doutb, 8'h5A);
    #2;
    rst = 1'b1;
    #1;
    chk("async_clear", doutb, 8'h00);
    wea = 1'b1; addra = 8'd3; dina = 8'h77; addrb = 8'd20;
    tick();
    chk("reset_hold", doutb, 8'h00);
    rst = 1'b0; wea = 1'b0; addrb = 8'd3;
    tick();
    chk("reset_nowrite", doutb, 8'h03);
    addrb = 8'd20;
    tick();
    chk("reset_retain", doutb, 8'h5A);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
